// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the fifo_wrap buffer.
//   fifo_status_t : registered status flags presented by the FIFO.
//   fifo_err_t    : sticky error flags.
//   fifo_flags()  : derives the status flags from a fill count and thresholds.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic full;
        logic almost_full;
        logic valid;
    } fifo_status_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    localparam fifo_status_t STATUS_RESET = '{
        empty:        1'b1,
        almost_empty: 1'b1,
        full:         1'b0,
        almost_full:  1'b0,
        valid:        1'b0
    };

    localparam fifo_err_t ERR_RESET = '{overflow: 1'b0, underflow: 1'b0};

    // A threshold at or above depth pins almost_full high; the explicit
    // compare also keeps depth - af from wrapping below zero.
    function automatic fifo_status_t fifo_flags(
        input int unsigned fill,
        input int unsigned ae,
        input int unsigned af,
        input int unsigned depth
    );
        fifo_status_t s;
        s.empty        = (fill == 0);
        s.almost_empty = (fill <= ae);
        s.full         = (fill == depth);
        s.almost_full  = (af >= depth) || (fill >= depth - af);
        s.valid        = (fill != 0);
        return s;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer register for the fifo_wrap buffer.
//   clk      : clock
//   reset    : synchronous active-low reset (pointer -> 0)
//   inc      : advance the pointer by one, wrapping DEPTH-1 -> 0
//   load     : load load_val (takes priority over inc)
//   load_val : value to load
//   ptr      : current pointer value
//   ptr_inc  : wrapped successor of ptr (combinational)
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH   = 24,
    parameter int PTRBITS = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               load,
    input  logic [PTRBITS-1:0] load_val,
    output logic [PTRBITS-1:0] ptr,
    output logic [PTRBITS-1:0] ptr_inc
);

    localparam logic [PTRBITS-1:0] LAST = PTRBITS'(DEPTH - 1);

    // Explicit compare against DEPTH-1 so non-power-of-two depths never alias.
    always_comb begin
        ptr_inc = (ptr == LAST) ? '0 : ptr + PTRBITS'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr_inc;
        end
    end

endmodule

// File: rtl/fifo_wrap.sv
// fifo_wrap: synchronous FIFO for any DEPTH >= 2, with runtime almost-empty /
// almost-full thresholds, FWFT or registered-read output, non-destructive
// circular replay and sticky overflow/underflow flags.
//
// Optional feature macro: FIFO_WRAP_PEAK_EN adds a peak_fill high-water mark.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   datain, write   : write data and request
//   read            : read/pop request
//   circular        : replay mode, reads move the cursor without freeing entries
//   clear_err       : clears overflow/underflow (and peak_fill when enabled)
//   ae_thresh       : almost_empty when fill <= ae_thresh
//   af_thresh       : almost_full when fill >= DEPTH - af_thresh
//   dataout         : read data
//   dataout_valid   : dataout is meaningful
//   fill_level      : number of stored entries
//   empty, almost_empty, full, almost_full : status flags
//   overflow, underflow : sticky error flags
//   peak_fill       : high-water mark of fill_level (FIFO_WRAP_PEAK_EN only)
module fifo_wrap
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 24,
    parameter int FWFT     = 1,
    parameter int PTRBITS  = $clog2(DEPTH),
    parameter int FILLBITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    datain,
    input  logic                write,
    input  logic                read,
    input  logic                circular,
    input  logic                clear_err,
    input  logic [FILLBITS-1:0] ae_thresh,
    input  logic [FILLBITS-1:0] af_thresh,
    output logic [WIDTH-1:0]    dataout,
    output logic                dataout_valid,
    output logic [FILLBITS-1:0] fill_level,
    output logic                empty,
    output logic                almost_empty,
    output logic                full,
    output logic                almost_full,
    output logic                overflow,
    output logic                underflow
`ifdef FIFO_WRAP_PEAK_EN
    ,
    output logic [FILLBITS-1:0] peak_fill
`endif
);

    localparam logic [FILLBITS-1:0] FULL_CNT = FILLBITS'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];

    logic [FILLBITS-1:0] fill_q;
    logic [FILLBITS-1:0] fill_nxt;
    fifo_status_t        status_q;
    fifo_status_t        status_nxt;
    fifo_err_t           err_q;

    logic [PTRBITS-1:0]  head, head_inc, head_nxt;
    logic [PTRBITS-1:0]  tail, tail_inc;
    logic [PTRBITS-1:0]  cursor, cursor_inc;
    logic [PTRBITS-1:0]  rd_addr;

    logic                rd_acc, wr_acc;
    logic                pop;
    logic                cur_inc, cur_load;
    logic [PTRBITS-1:0]  cur_load_val;
    logic                ovf_evt, unf_evt;

    logic [WIDTH-1:0]    dout_q;
    logic                rd_valid_q;

    // ------------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------------
    always_comb begin
        rd_acc  = read && (fill_q != '0);
        pop     = rd_acc && !circular;
        // In replay mode a read never frees space, so only a true pop lets
        // a write into a full FIFO.
        wr_acc  = write && ((fill_q != FULL_CNT) || pop);
        ovf_evt = write && !wr_acc;
        unf_evt = read && (fill_q == '0);
    end

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    always_comb begin
        head_nxt = pop ? head_inc : head;
    end

    // Outside replay the cursor is reloaded with next-head every edge, which
    // keeps cursor == head and also covers the circular 1->0 realignment.
    // In replay the cursor steps, wrapping back to head when it would reach tail.
    always_comb begin
        cur_inc      = 1'b0;
        cur_load     = 1'b0;
        cur_load_val = head_nxt;
        if (!circular) begin
            cur_load = 1'b1;
        end else if (rd_acc) begin
            if (cursor_inc == tail) begin
                cur_load     = 1'b1;
                cur_load_val = head;
            end else begin
                cur_inc = 1'b1;
            end
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTRBITS(PTRBITS)) u_head (
        .clk      (clk),
        .reset    (reset),
        .inc      (pop),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (head),
        .ptr_inc  (head_inc)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTRBITS(PTRBITS)) u_tail (
        .clk      (clk),
        .reset    (reset),
        .inc      (wr_acc),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail),
        .ptr_inc  (tail_inc)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTRBITS(PTRBITS)) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .inc      (cur_inc),
        .load     (cur_load),
        .load_val (cur_load_val),
        .ptr      (cursor),
        .ptr_inc  (cursor_inc)
    );

    // Read from head whenever not replaying: identical to cursor in steady
    // state, and correct on the edge leaving replay where the pop uses head
    // while the cursor is only being realigned.
    always_comb begin
        rd_addr = circular ? cursor : head;
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem[tail] <= datain;
        end
    end

    // ------------------------------------------------------------------
    // Fill count and flags
    // ------------------------------------------------------------------
    always_comb begin
        fill_nxt = fill_q;
        if (circular) begin
            if (wr_acc) begin
                fill_nxt = fill_q + FILLBITS'(1);
            end
        end else if (wr_acc && !rd_acc) begin
            fill_nxt = fill_q + FILLBITS'(1);
        end else if (rd_acc && !wr_acc) begin
            fill_nxt = fill_q - FILLBITS'(1);
        end
        status_nxt = fifo_flags(32'(fill_nxt), 32'(ae_thresh), 32'(af_thresh), DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_q   <= '0;
            status_q <= STATUS_RESET;
            err_q    <= ERR_RESET;
        end else begin
            fill_q   <= fill_nxt;
            status_q <= status_nxt;
            // A new error in the same cycle as clear_err wins.
            err_q.overflow  <= ovf_evt || (err_q.overflow  && !clear_err);
            err_q.underflow <= unf_evt || (err_q.underflow && !clear_err);
        end
    end

    // ------------------------------------------------------------------
    // Registered-read output path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem[rd_addr];
            end
        end
    end

`ifdef FIFO_WRAP_PEAK_EN
    logic [FILLBITS-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (!reset || clear_err) begin
            peak_q <= '0;
        end else if (fill_nxt > peak_q) begin
            peak_q <= fill_nxt;
        end
    end

    assign peak_fill = peak_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        if (FWFT != 0) begin
            dataout       = status_q.valid ? mem[rd_addr] : '0;
            dataout_valid = status_q.valid;
        end else begin
            dataout       = dout_q;
            dataout_valid = rd_valid_q;
        end
        fill_level   = fill_q;
        empty        = status_q.empty;
        almost_empty = status_q.almost_empty;
        full         = status_q.full;
        almost_full  = status_q.almost_full;
        overflow     = err_q.overflow;
        underflow    = err_q.underflow;
    end

endmodule

// File: tb/tb_fifo_wrap.sv
// tb_fifo_wrap: directed bench for fifo_wrap. One DUT in FWFT mode, one in
// registered-read mode; read data is checked by scoreboard monitors.
module tb_fifo_wrap;

    localparam int W  = 32;
    localparam int D  = 24;
    localparam int FB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  datain;
    logic          write, read, circular, clear_err;
    logic [FB-1:0] ae_thresh, af_thresh;
    logic [W-1:0]  dataout;
    logic          dataout_valid;
    logic [FB-1:0] fill_level;
    logic          empty, almost_empty, full, almost_full, overflow, underflow;

    logic [W-1:0]  datain0;
    logic          write0, read0, clear_err0;
    logic [W-1:0]  dataout0;
    logic          dataout_valid0;
    logic [FB-1:0] fill_level0;
    logic          empty0, almost_empty0, full0, almost_full0, overflow0, underflow0;
`ifdef FIFO_WRAP_PEAK_EN
    logic [FB-1:0] peak, peak0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp0_q[$];

    always #5 clk = ~clk;

    fifo_wrap #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut (
        .clk(clk), .reset(reset), .datain(datain), .write(write), .read(read),
        .circular(circular), .clear_err(clear_err),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh),
        .dataout(dataout), .dataout_valid(dataout_valid), .fill_level(fill_level),
        .empty(empty), .almost_empty(almost_empty), .full(full),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
`ifdef FIFO_WRAP_PEAK_EN
        , .peak_fill(peak)
`endif
    );

    fifo_wrap #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .datain(datain0), .write(write0), .read(read0),
        .circular(1'b0), .clear_err(clear_err0),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh),
        .dataout(dataout0), .dataout_valid(dataout_valid0), .fill_level(fill_level0),
        .empty(empty0), .almost_empty(almost_empty0), .full(full0),
        .almost_full(almost_full0), .overflow(overflow0), .underflow(underflow0)
`ifdef FIFO_WRAP_PEAK_EN
        , .peak_fill(peak0)
`endif
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FWFT monitor: a read handshake is about to occur, head word must match.
    always @(negedge clk) begin
        if (reset && read && dataout_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fwft_data: got 0x%0h expected none (queue empty)", dataout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (dataout !== e) begin
                    n_fail++;
                    $display("FAIL fwft_data: got 0x%0h expected 0x%0h at %0t", dataout, e, $time);
                end
            end
        end
    end

    // Registered-read monitor: compare whenever the DUT presents valid data.
    always @(negedge clk) begin
        if (reset && dataout_valid0) begin
            n_checks++;
            if (exp0_q.size() == 0) begin
                n_fail++;
                $display("FAIL reg_data: got 0x%0h expected none (queue empty)", dataout0);
            end else begin
                logic [W-1:0] e;
                e = exp0_q.pop_front();
                if (dataout0 !== e) begin
                    n_fail++;
                    $display("FAIL reg_data: got 0x%0h expected 0x%0h at %0t", dataout0, e, $time);
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fill"},  W'(fill_level), 0);
        chk({tag, "_empty"}, W'(empty), 1);
        chk({tag, "_ae"},    W'(almost_empty), 1);
        chk({tag, "_full"},  W'(full), 0);
        chk({tag, "_af"},    W'(almost_full), 0);
        chk({tag, "_valid"}, W'(dataout_valid), 0);
        chk({tag, "_ovf"},   W'(overflow), 0);
        chk({tag, "_unf"},   W'(underflow), 0);
        chk({tag, "_dout"},  dataout, 0);
    endtask

    initial begin
        reset = 1'b0; datain = '0; write = 0; read = 0; circular = 0; clear_err = 0;
        ae_thresh = FB'(2); af_thresh = FB'(3);
        datain0 = '0; write0 = 0; read0 = 0; clear_err0 = 0;
        tick(); tick();
        chk_reset_state("rst");
        chk("rst0_valid", W'(dataout_valid0), 0);
        chk("rst0_dout", dataout0, 0);
        reset = 1'b1;

        // Fill 0..24 with threshold checks at every level.
        for (int i = 0; i < D; i++) begin
            write = 1; datain = 32'h100 + W'(i);
            tick();
            chk("fill_lvl", W'(fill_level), W'(i + 1));
            chk("fill_full", W'(full), W'(i + 1 == D));
            chk("fill_ae", W'(almost_empty), W'(i + 1 <= 2));
            chk("fill_af", W'(almost_full), W'(i + 1 >= 21));
            chk("fill_empty", W'(empty), 0);
        end
        datain = 32'h999;
        tick();
        chk("ovf_flag", W'(overflow), 1);
        chk("ovf_fill", W'(fill_level), 24);
        write = 0; clear_err = 1;
        tick();
        chk("ovf_clr", W'(overflow), 0);
        clear_err = 0;

        // Write while full with simultaneous pop.
        write = 1; datain = 32'hAAA; read = 1; exp_q.push_back(32'h100);
        tick();
        write = 0;
        chk("wr_rd_full_fill", W'(fill_level), 24);
        chk("wr_rd_full_ovf", W'(overflow), 0);
        for (int i = 1; i < D; i++) begin
            exp_q.push_back(32'h100 + W'(i));
            tick();
        end
        exp_q.push_back(32'hAAA);
        tick();
        read = 0;
        chk("drain_empty", W'(empty), 1);
        chk("drain_fill", W'(fill_level), 0);
        chk("drain_unf", W'(underflow), 0);

        // Wrap: pointers sit at 1 here, so 40 pairs cross 23 -> 0.
        for (int i = 0; i < 40; i++) begin
            write = 1; datain = 32'h2000 + W'(i);
            tick();
            write = 0;
            chk("wrap_fill1", W'(fill_level), 1);
            read = 1; exp_q.push_back(32'h2000 + W'(i));
            tick();
            read = 0;
            chk("wrap_fill0", W'(fill_level), 0);
        end

        // Circular replay of A,B,C.
        write = 1; datain = 32'hA0; tick();
        datain = 32'hB0; tick();
        datain = 32'hC0; tick();
        write = 0; circular = 1; read = 1;
        for (int i = 0; i < 7; i++) begin
            case (i % 3)
                0: exp_q.push_back(32'hA0);
                1: exp_q.push_back(32'hB0);
                default: exp_q.push_back(32'hC0);
            endcase
            tick();
            chk("circ_fill", W'(fill_level), 3);
        end
        read = 0; circular = 0;
        tick();
        chk("circ_exit_dout", dataout, 32'hA0);
        read = 1;
        exp_q.push_back(32'hA0); tick();
        exp_q.push_back(32'hB0); tick();
        exp_q.push_back(32'hC0); tick();
        read = 0;
        chk("circ_pop_empty", W'(empty), 1);

        // Underflow, clear_err colliding with a new error, then clear.
        read = 1;
        tick();
        chk("unf_flag", W'(underflow), 1);
        clear_err = 1;
        tick();
        chk("unf_err_wins", W'(underflow), 1);
        read = 0;
        tick();
        chk("unf_clr", W'(underflow), 0);
        clear_err = 0;

        // Registered-read DUT.
        write0 = 1; datain0 = 32'h55;
        tick();
        write0 = 0;
        chk("reg_valid_pre", W'(dataout_valid0), 0);
        read0 = 1; exp0_q.push_back(32'h55);
        tick();
        read0 = 0;
        chk("reg_valid_1cyc", W'(dataout_valid0), 1);
        chk("reg_dout_1cyc", dataout0, 32'h55);
        tick();
        chk("reg_valid_drop", W'(dataout_valid0), 0);
        chk("reg_dout_hold", dataout0, 32'h55);
        read0 = 1;
        tick();
        read0 = 0;
        chk("reg_unf", W'(underflow0), 1);
        chk("reg_unf_valid", W'(dataout_valid0), 0);
        clear_err0 = 1;
        tick();
        clear_err0 = 0;
        chk("reg_unf_clr", W'(underflow0), 0);

        // af_thresh >= DEPTH forces almost_full even when empty.
        af_thresh = FB'(24);
        tick();
        chk("af_force", W'(almost_full), 1);
        af_thresh = FB'(3);
        tick();
        chk("af_restore", W'(almost_full), 0);

        // Reset in the middle of filling.
        for (int i = 0; i < 10; i++) begin
            write = 1; datain = 32'h300 + W'(i);
            tick();
        end
        chk("mid_fill", W'(fill_level), 10);
        reset = 0;
        tick();
        write = 0;
        chk_reset_state("midrst");
        reset = 1;
        tick();

        chk("sb_fwft_drained", W'(exp_q.size()), 0);
        chk("sb_reg_drained", W'(exp0_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
